insn_buffer: RTL and testbench
==============================

INSN_BUFFER -- requirements
Module: insn_buffer

Interface
REQ-001 Parameter N, default `N: superscalar width; lanes per cycle in and out.
REQ-002 Parameter DEPTH, default 8: entry capacity; SHALL be a power of 2 and >= 2*N.
REQ-003 Parameter ENTRY_W, default 128: opaque per-instruction payload width (PC, inst, NPC, prediction bits).
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low; 0 at a rising edge resets all state.
REQ-006 squash  input  1  flush all buffered entries (mispredict from commit).
REQ-007 if_valid  input  N  fetch lane valid; lanes SHALL be a contiguous prefix from lane 0.
REQ-008 if_data  input  N*ENTRY_W  fetch payload; lane i at bits [i*ENTRY_W +: ENTRY_W].
REQ-009 stall  input  1  dispatch cannot accept this cycle (structural hazard from the OoO core).
REQ-010 id_valid  output  N  dispatch lane valid, contiguous prefix from lane 0.
REQ-011 id_data  output  N*ENTRY_W  dispatch payload, oldest entry in lane 0.
REQ-012 if_stall  output  1  fetch must hold; incoming lanes are dropped while high.
REQ-013 count_out  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-014 Storage is a circular buffer with head and tail pointers of clog2(DEPTH) bits and an occupancy counter.
REQ-015 if_stall SHALL be combinational: (count > DEPTH-N) || squash.
REQ-016 Enqueue: when if_stall=0, write lane i to slot (tail+i) mod DEPTH for each valid lane; tail advances by popcount(if_valid).
REQ-017 Enqueue is all-or-nothing; when if_stall=1, no lanes are written.
REQ-018 Enqueue eligibility uses the current count, not the post-dequeue count.
REQ-019 Outputs are combinational from registered state: lane i presents slot (head+i) mod DEPTH, with id_valid[i] = (i < count) && !squash.
REQ-020 There is no bypass: an entry enqueued in cycle t is first visible on id_* in cycle t+1.
REQ-021 Dequeue: when stall=0 and squash=0, pop deq = min(count, N) entries; head advances by deq.
REQ-022 When stall=1, head is unchanged and id_valid/id_data hold stable until consumed (new tail entries may only fill lanes beyond the current count).
REQ-023 Simultaneous enqueue and dequeue: count_next = count + enq - deq; the counter never exceeds DEPTH or underflows.
REQ-024 Wrap-around: pointer arithmetic is modulo DEPTH; lane order is preserved across the wrap.
REQ-025 Squash: next cycle head=tail=0 and count=0; same-cycle enqueue and dequeue are suppressed.
REQ-026 Empty buffer (count=0): id_valid=0 and id_data is don't-care.
REQ-027 A non-prefix if_valid pattern is illegal; the bench SHALL flag it with an assertion.

Reset
REQ-028 reset=0 at an edge sets head=0, tail=0, count=0 and clears all valid state; payload storage need not be cleared.
REQ-029 Reset has priority over squash, enqueue and dequeue, including mid-operation.
REQ-030 Outputs in the cycle after reset: id_valid=0, count_out=0, if_stall=0 (squash low).

Verification (N=2, DEPTH=8)
REQ-031 Fill: if_valid=11 for 4 cycles with stall=1 -> count_out 2,4,6,8; if_stall=1 from count=7.. i.e. after the 4th enqueue (count 8 > 6); the 5th push is dropped.
REQ-032 Drain order: enqueue A,B then C,D, then stall=0 -> id lanes show (A,B), then (C,D), then id_valid=00.
REQ-033 Wrap: with head=tail=7 and count=0, enqueue X,Y -> X in slot 7, Y in slot 0; next cycle lane0=X, lane1=Y.
REQ-034 Simultaneous: count=6, enqueue 2 and dequeue 2 in the same cycle -> count stays 6 and payload order is intact.
REQ-035 Squash with count=5 and if_valid=11 -> id_valid=00 that cycle; next cycle count=0 and the incoming lanes are not stored.
REQ-036 Reset mid-stream: count=3, reset=0 for one edge -> count_out=0 and id_valid=00 the next cycle; a subsequent enqueue lands at slot 0.

Source files
------------

// File: rtl/insn_buffer.sv
// insn_buffer: N-wide circular instruction buffer between fetch and dispatch (clock/reset, squash, if_valid/if_data/if_stall in, stall in, id_valid/id_data/count_out out)
module insn_buffer #(
  parameter int N = 2,
  parameter int DEPTH = 8,
  parameter int ENTRY_W = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic [N-1:0]         if_valid,
  input  logic [N*ENTRY_W-1:0] if_data,
  input  logic                 stall,
  output logic [N-1:0]         id_valid,
  output logic [N*ENTRY_W-1:0] id_data,
  output logic                 if_stall,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, enq, deq;
  assign if_stall = (count > CW'(DEPTH-N)) || squash;
  assign deq = (stall || squash) ? '0 : (count < CW'(N) ? count : CW'(N));
  assign count_out = count;
  always_comb begin
    enq = '0;
    for (int k = 0; k < N; k++) enq = enq + CW'(if_valid[k]);
    enq = if_stall ? '0 : enq;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (squash) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(deq);
      tail <= tail + AW'(enq);
      count <= count + enq - deq;
    end
  end
  always_ff @(posedge clock) begin
    for (int k = 0; k < N; k++)
      if (!if_stall && if_valid[k]) mem[tail + AW'(k)] <= if_data[k*ENTRY_W +: ENTRY_W];
  end
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign id_data[i*ENTRY_W +: ENTRY_W] = mem[head + AW'(i)];
    assign id_valid[i] = (CW'(i) < count) && !squash;
  end
endmodule

// File: tb/tb_insn_buffer.sv
// tb_insn_buffer: randomized and directed self-checking bench for insn_buffer against a queue model
module tb_insn_buffer;
  localparam int N = 2;
  localparam int DEPTH = 8;
  localparam int W = 32;
  logic clock = 0;
  logic reset, squash, stall;
  logic [N-1:0] if_valid;
  logic [N*W-1:0] if_data;
  logic [N-1:0] id_valid;
  logic [N*W-1:0] id_data;
  logic if_stall;
  logic [$clog2(DEPTH+1)-1:0] count_out;
  int total = 0;
  int passes = 0;
  logic [W-1:0] q[$];
  bit started = 0;
  insn_buffer #(.N(N), .DEPTH(DEPTH), .ENTRY_W(W)) dut (
    .clock(clock), .reset(reset), .squash(squash), .if_valid(if_valid), .if_data(if_data),
    .stall(stall), .id_valid(id_valid), .id_data(id_data), .if_stall(if_stall), .count_out(count_out)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [W-1:0] lane(input int i);
    return id_data[i*W +: W];
  endfunction
  always @(posedge clock)
    assert ((if_valid & (if_valid + 1'b1)) == '0) else $error("illegal non-prefix if_valid %b", if_valid);
  always @(negedge clock) begin
    int cnt, d;
    bit full;
    cnt = q.size();
    full = cnt > DEPTH - N;
    if (started) begin
      check("m_count", 64'(count_out), 64'(cnt));
      check("m_if_stall", 64'(if_stall), 64'(full || squash));
      for (int i = 0; i < N; i++) begin
        check("m_id_valid", 64'(id_valid[i]), 64'(i < cnt && !squash));
        if (i < cnt && !squash) check("m_id_data", 64'(lane(i)), 64'(q[i]));
      end
    end
    if (!reset || squash) q.delete();
    else begin
      d = stall ? 0 : (cnt < N ? cnt : N);
      repeat (d) void'(q.pop_front());
      if (!full) for (int i = 0; i < N; i++) if (if_valid[i]) q.push_back(if_data[i*W +: W]);
    end
    if (!reset) started = 1;
  end
  task automatic drive(input logic rn, input logic sq, input logic st, input logic [N-1:0] v,
                       input logic [W-1:0] d0, input logic [W-1:0] d1);
    reset = rn; squash = sq; stall = st; if_valid = v; if_data = {d1, d0};
    @(posedge clock); #1;
  endtask
  task automatic do_reset();
    drive(0, 0, 1, 2'b00, 0, 0);
  endtask
  initial begin
    reset = 0; squash = 0; stall = 1; if_valid = 0; if_data = 0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_count", 64'(count_out), 0);
    check("reset_id_valid", 64'(id_valid), 0);
    check("reset_if_stall", 64'(if_stall), 0);
    drive(1, 0, 1, 2'b11, 32'h1, 32'h2);
    check("fill_c2", 64'(count_out), 2);
    drive(1, 0, 1, 2'b11, 32'h3, 32'h4);
    check("fill_c4", 64'(count_out), 4);
    drive(1, 0, 1, 2'b11, 32'h5, 32'h6);
    check("fill_c6", 64'(count_out), 6);
    check("fill_nostall6", 64'(if_stall), 0);
    drive(1, 0, 1, 2'b11, 32'h7, 32'h8);
    check("fill_c8", 64'(count_out), 8);
    check("fill_stall8", 64'(if_stall), 1);
    drive(1, 0, 1, 2'b11, 32'h9, 32'hA);
    check("fill_drop", 64'(count_out), 8);
    check("fill_head", 64'(lane(0)), 32'h1);
    do_reset();
    drive(1, 0, 1, 2'b11, 32'hA, 32'hB);
    drive(1, 0, 1, 2'b11, 32'hC, 32'hD);
    stall = 0; if_valid = 0; #1;
    check("drain_ab0", 64'(lane(0)), 32'hA);
    check("drain_ab1", 64'(lane(1)), 32'hB);
    check("drain_abv", 64'(id_valid), 2'b11);
    drive(1, 0, 0, 2'b00, 0, 0);
    check("drain_cd0", 64'(lane(0)), 32'hC);
    check("drain_cd1", 64'(lane(1)), 32'hD);
    drive(1, 0, 0, 2'b00, 0, 0);
    check("drain_empty", 64'(id_valid), 2'b00);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 2'b11, W'(16 + 2*i), W'(17 + 2*i));
    drive(1, 0, 1, 2'b01, 32'h22, 0);
    check("wrap_c7", 64'(count_out), 7);
    repeat (4) drive(1, 0, 0, 2'b00, 0, 0);
    check("wrap_empty", 64'(count_out), 0);
    drive(1, 0, 1, 2'b11, 32'hAAAA, 32'hBBBB);
    check("wrap_x", 64'(lane(0)), 32'hAAAA);
    check("wrap_y", 64'(lane(1)), 32'hBBBB);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 2'b11, W'(48 + 2*i), W'(49 + 2*i));
    drive(1, 0, 0, 2'b11, 32'h70, 32'h71);
    check("simul_c6", 64'(count_out), 6);
    check("simul_l0", 64'(lane(0)), 32'd50);
    repeat (2) drive(1, 0, 0, 2'b00, 0, 0);
    check("simul_pq0", 64'(lane(0)), 32'h70);
    check("simul_pq1", 64'(lane(1)), 32'h71);
    do_reset();
    drive(1, 0, 1, 2'b11, 1, 2);
    drive(1, 0, 1, 2'b11, 3, 4);
    drive(1, 0, 1, 2'b01, 5, 0);
    squash = 1; if_valid = 2'b11; if_data = {32'hEE, 32'hFF}; #1;
    check("squash_valid", 64'(id_valid), 0);
    check("squash_if_stall", 64'(if_stall), 1);
    drive(1, 1, 1, 2'b11, 32'hFF, 32'hEE);
    check("squash_count", 64'(count_out), 0);
    drive(1, 0, 1, 2'b11, 1, 2);
    drive(1, 0, 1, 2'b01, 3, 0);
    drive(0, 0, 0, 2'b11, 7, 7);
    check("rst_mid_count", 64'(count_out), 0);
    check("rst_mid_valid", 64'(id_valid), 0);
    drive(1, 0, 1, 2'b01, 32'h5A, 0);
    check("rst_mid_lane0", 64'(lane(0)), 32'h5A);
    check("rst_mid_c1", 64'(count_out), 1);
    for (int c = 0; c < 600; c++) begin
      logic [1:0] v;
      v = $urandom_range(0, 2) == 0 ? 2'b00 : ($urandom_range(0, 1) ? 2'b11 : 2'b01);
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 4,
            v, $urandom, $urandom);
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
